// File: rtl/fsm_handshake_defs_pkg.sv
// Shared go/done handshake definitions: state encodings and line polarities,
// common to the go initiator and the LED counting FSM it drives.
package fsm_handshake_defs;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_LOW = 2'd2,
    ST_ERR      = 2'd3
  } hs_state_t;

  // go is active-low on the wire, done is active-high
  localparam logic GO_ACTIVE     = 1'b0;
  localparam logic GO_INACTIVE   = 1'b1;
  localparam logic DONE_ACTIVE   = 1'b1;
  localparam logic DONE_INACTIVE = 1'b0;

  // trigger button idles high and pulls low when pressed
  localparam logic TRIG_INACTIVE = 1'b1;

  // run tally shown on the LEDs, wraps 15 -> 0
  function automatic logic [3:0] led_next(input logic [3:0] cur);
    return cur + 4'd1;
  endfunction

endpackage

// File: rtl/fsm_go_initiator_button_debouncer.sv
// Button conditioner: 2-flop synchronizer, stability counter and a one-cycle
// press pulse on each accepted transition away from the idle level.
module button_debouncer
  import fsm_handshake_defs::*;
#(
  parameter int   DEBOUNCE_CYCLES = 120000,
  parameter logic IDLE_LEVEL      = TRIG_INACTIVE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             level;
  logic [CNT_W-1:0] stable_cnt;

  // bring the raw button into the clk domain, idle level out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= IDLE_LEVEL;
      sync_q2 <= IDLE_LEVEL;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
    end
  end

  // count consecutive cycles the synced level disagrees with the accepted one;
  // any bounce back to the accepted level restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level      <= IDLE_LEVEL;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_q2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        level      <= sync_q2;
        stable_cnt <= '0;
        press      <= (sync_q2 != IDLE_LEVEL);
      end else begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fsm_go_initiator.sv
// Requester side of the go/done handshake: a debounced button press raises go,
// done ends the run and bumps the LED tally, silence past the timeout flags ERR.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | no request outstanding, waiting for a button press
// ST_REQ      | go held low, waiting for done, timeout running
// ST_WAIT_LOW | run counted, waiting for done to drop before re-arming
// ST_ERR      | counter never answered; timeout_led lit until next press
module fsm_go_initiator
  import fsm_handshake_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int TIMEOUT_CYCLES  = 100000000
) (
  input  logic       clk,
  input  logic       rst_btn,
  input  logic       trig_btn,
  input  logic       done_sig,
  output logic       go_n,
  output logic       busy,
  output logic [3:0] led,
  output logic       timeout_led
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  hs_state_t       state;
  logic [TO_W-1:0] tmo_cnt;
  logic            press;
  logic            done_q1;
  logic            done_sync;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .IDLE_LEVEL      (TRIG_INACTIVE)
  ) u_trig_db (
    .clk   (clk),
    .rst_n (rst_btn),
    .btn   (trig_btn),
    .press (press)
  );

  // done comes from the counting FSM's divided clock, so resynchronize it
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      done_q1   <= DONE_INACTIVE;
      done_sync <= DONE_INACTIVE;
    end else begin
      done_q1   <= done_sig;
      done_sync <= done_q1;
    end
  end

  // handshake FSM with registered outputs, timeout counter and run tally;
  // done is tested before the timeout so a coincident answer still counts
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state       <= ST_IDLE;
      go_n        <= GO_INACTIVE;
      busy        <= 1'b0;
      led         <= 4'd0;
      timeout_led <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (press) begin
            state   <= ST_REQ;
            go_n    <= GO_ACTIVE;
            busy    <= 1'b1;
            tmo_cnt <= '0;
          end
        end
        ST_REQ: begin
          tmo_cnt <= tmo_cnt + TO_W'(1);
          if (done_sync == DONE_ACTIVE) begin
            state <= ST_WAIT_LOW;
            go_n  <= GO_INACTIVE;
            led   <= led_next(led);
          end else if (tmo_cnt == TO_LAST) begin
            state       <= ST_ERR;
            go_n        <= GO_INACTIVE;
            busy        <= 1'b0;
            timeout_led <= 1'b1;
          end
        end
        ST_WAIT_LOW: begin
          if (done_sync == DONE_INACTIVE) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_ERR: begin
          if (press) begin
            state       <= ST_IDLE;
            timeout_led <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          go_n        <= GO_INACTIVE;
          busy        <= 1'b0;
          timeout_led <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_go_initiator.sv
// Scoreboard bench for fsm_go_initiator: stimulus tasks push the expected
// output changes (with the cycle they are due) and a monitor pops and checks
// them whenever the observed outputs change.
module tb_fsm_go_initiator;

  localparam int DB = 4;
  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       rst_btn = 1'b1;
  logic       trig_btn = 1'b1;
  logic       done_sig = 1'b0;
  logic       go_n;
  logic       busy;
  logic [3:0] led;
  logic       timeout_led;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int m_led = 0;

  typedef struct {
    int         cyc;
    logic [6:0] val;
  } exp_t;

  exp_t       exp_q[$];
  logic [6:0] prev;

  fsm_go_initiator #(
    .DEBOUNCE_CYCLES (DB),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk         (clk),
    .rst_btn     (rst_btn),
    .trig_btn    (trig_btn),
    .done_sig    (done_sig),
    .go_n        (go_n),
    .busy        (busy),
    .led         (led),
    .timeout_led (timeout_led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] pk(input logic g, input logic b, input int l, input logic t);
    logic [3:0] l4;
    l4 = 4'(l);
    return {g, b, l4, t};
  endfunction

  function automatic logic [6:0] obs();
    return {go_n, busy, led, timeout_led};
  endfunction

  task automatic push(input int c, input logic [6:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic show_fail(input string name, input int c_got, input logic [6:0] got,
                           input int c_want, input logic [6:0] want);
    $display("FAIL %s: got go_n=%b busy=%b led=%0d timeout_led=%b at cycle %0d, want go_n=%b busy=%b led=%0d timeout_led=%b at cycle %0d",
             name, got[6], got[5], got[4:1], got[0], c_got,
             want[6], want[5], want[4:1], want[0], c_want);
  endtask

  task automatic check_now(input string name, input logic [6:0] want);
    logic [6:0] got;
    got = obs();
    vectors++;
    if (got !== want) begin
      miscompares++;
      show_fail(name, cyc, got, cyc, want);
    end
  endtask

  // pops one expectation per observed output change; overdue ones are misses
  task automatic monitor();
    exp_t       e;
    logic [6:0] cur;
    prev = pk(1'b1, 1'b0, 0, 1'b0);
    forever begin
      @(negedge clk);
      if (!rst_btn) begin
        prev = pk(1'b1, 1'b0, 0, 1'b0);
      end else begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          vectors++;
          miscompares++;
          show_fail("missing_event", cyc, obs(), e.cyc, e.val);
        end
        cur = obs();
        if (cur !== prev) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            show_fail("unexpected_event", cyc, cur, cyc, prev);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || cur !== e.val) begin
              miscompares++;
              show_fail("event", cyc, cur, e.cyc, e.val);
            end
          end
          prev = cur;
        end
      end
    end
  endtask

  // press from ERR: back to IDLE 2 sync + DB + 1 edges later, no run started
  task automatic clear_err();
    int n;
    @(negedge clk);
    n = cyc;
    push(n + 2 + DB + 1, pk(1'b1, 1'b0, m_led, 1'b0));
    trig_btn = 1'b0;
    repeat (8) @(negedge clk);
    trig_btn = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  // one press from IDLE; done rises `delay` cycles after go_n falls (delay<0: never)
  task automatic run(input int hold, input int delay, input int len, input bit extra);
    int n;
    int p;
    bit timed_out;
    @(negedge clk);
    n = cyc;
    p = n + 2 + DB + 1;
    push(p, pk(1'b0, 1'b1, m_led, 1'b0));
    if (delay >= 0 && delay + 3 <= TO) begin
      timed_out = 1'b0;
      m_led = (m_led + 1) % 16;
      push(p + delay + 3, pk(1'b1, 1'b1, m_led, 1'b0));
      push(p + delay + len + 3, pk(1'b1, 1'b0, m_led, 1'b0));
    end else begin
      timed_out = 1'b1;
      push(p + TO, pk(1'b1, 1'b0, m_led, 1'b1));
    end
    fork
      begin
        trig_btn = 1'b0;
        repeat (hold) @(negedge clk);
        trig_btn = 1'b1;
        if (extra) begin
          repeat (8) @(negedge clk);
          trig_btn = 1'b0;
          repeat (6) @(negedge clk);
          trig_btn = 1'b1;
        end
      end
      begin
        if (delay >= 0) begin
          while (cyc < p + delay) @(negedge clk);
          done_sig = 1'b1;
          repeat (len) @(negedge clk);
          done_sig = 1'b0;
        end
      end
    join
    if (timed_out) begin
      while (cyc < p + TO + 1) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    if (timed_out) clear_err();
  endtask

  initial begin
    int hold;
    int delay;
    int len;
    int led_start;
    bit extra;
    int n;

    // asynchronous reset asserted mid-cycle
    #12 rst_btn = 1'b0;
    #1 check_now("reset_async", pk(1'b1, 1'b0, 0, 1'b0));
    @(negedge clk);
    #2 rst_btn = 1'b1;
    fork
      monitor();
    join_none
    repeat (5) @(negedge clk);

    // bouncing button never settles long enough
    for (int i = 0; i < 10; i++) begin
      trig_btn = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) @(negedge clk);
    end
    trig_btn = 1'b1;
    repeat (12) @(negedge clk);
    check_now("bounce_no_run", pk(1'b1, 1'b0, 0, 1'b0));

    // single run: 10-cycle press, done high 8 cycles starting 20 cycles after press
    run(10, 20 - (2 + DB + 1), 8, 1'b0);
    check_now("single_run_led", pk(1'b1, 1'b0, 1, 1'b0));

    // timeout with done never answering, then a press clears ERR
    run(8, -1, 0, 1'b0);
    check_now("timeout_cleared", pk(1'b1, 1'b0, 1, 1'b0));

    // done synced in the very cycle the timeout expires, and one cycle too late
    run(8, TO - 3, 5, 1'b0);
    run(8, TO - 2, 5, 1'b0);

    // sixteen completed runs wrap the tally; some with an ignored extra press
    led_start = m_led;
    for (int i = 0; i < 16; i++) begin
      hold  = $urandom_range(12, 6);
      delay = $urandom_range(40, 0);
      len   = $urandom_range(10, 1);
      extra = ($urandom_range(1, 0) == 1) && (delay >= hold + 6);
      run(hold, delay, len, extra);
    end
    check_now("wrap16", pk(1'b1, 1'b0, led_start, 1'b0));

    // random mix of answered and timed-out runs
    for (int i = 0; i < 10; i++) begin
      hold  = $urandom_range(12, 6);
      delay = $urandom_range(60, 0);
      len   = $urandom_range(10, 1);
      run(hold, delay, len, 1'b0);
    end
    check_now("random_mix_idle", pk(1'b1, 1'b0, m_led, 1'b0));

    // make sure the tally is nonzero, then reset in the middle of a request
    if (m_led == 0) run(8, 5, 3, 1'b0);
    @(negedge clk);
    n = cyc;
    push(n + 2 + DB + 1, pk(1'b0, 1'b1, m_led, 1'b0));
    trig_btn = 1'b0;
    repeat (8) @(negedge clk);
    trig_btn = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_btn = 1'b0;
    #1 check_now("reset_mid_run", pk(1'b1, 1'b0, 0, 1'b0));
    exp_q.delete();
    m_led = 0;
    @(negedge clk);
    #2 rst_btn = 1'b1;
    repeat (8) @(negedge clk);
    run(8, 10, 4, 1'b0);
    check_now("count_restarts", pk(1'b1, 1'b0, 1, 1'b0));

    repeat (20) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: %0d expected events still pending, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
